// File: rtl/mont_pkg.sv
// Shared constants and state type for the Montgomery-domain encoder and the
// multiply/reduction stages that sit next to it in the NTT datapath.
package mont_pkg;

    localparam int unsigned MONT_Q   = 3329;
    localparam int unsigned MONT_K   = 18;
    localparam int unsigned MONT_DW  = 16;

    // 2^18 mod Q and 2^36 mod Q, reused by the later multiply stage
    localparam int unsigned R_MOD_Q  = 2482;
    localparam int unsigned R2_MOD_Q = 1674;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } enc_state_t;

endpackage

// File: rtl/mod_dbl_add.sv
// One Horner step of modular double-and-add: o_acc = (2*i_acc + i_b) mod Q.
// Requires i_acc < Q <= 2^(DW-1), so one conditional subtract is enough.
module mod_dbl_add #(
    parameter int unsigned DW = 16,
    parameter int unsigned Q  = 3329
) (
    input  logic [DW-1:0] i_acc,
    input  logic          i_b,
    output logic [DW-1:0] o_acc
);

    localparam logic [DW:0] Q_EXT = (DW+1)'(Q);

    logic [DW:0] w_t;

    assign w_t   = {i_acc, 1'b0} + {{DW{1'b0}}, i_b};
    assign o_acc = (w_t >= Q_EXT) ? DW'(w_t - Q_EXT) : DW'(w_t);

endmodule

// File: rtl/mont_dom_enc.sv
// Serial Montgomery-domain encoder: y = (x * 2^K) mod Q, computed MSB first by
// Horner's rule over the DW data bits followed by K zero bits.
module mont_dom_enc
    import mont_pkg::*;
#(
    parameter int unsigned Q  = MONT_Q,
    parameter int unsigned DW = MONT_DW,
    parameter int unsigned K  = MONT_K
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          busy
);

    localparam int unsigned   STEPS = DW + K;
    localparam int unsigned   CW    = $clog2(STEPS);
    localparam logic [CW-1:0] LAST  = CW'(STEPS - 1);

    enc_state_t    r_state;
    enc_state_t    w_next;
    logic [DW-1:0] r_shift;
    logic [DW-1:0] r_acc;
    logic [DW-1:0] w_acc_nxt;
    logic [CW-1:0] r_cnt;
    logic          w_load;
    logic          w_step;

    // Zero fill means the MSB feeds b = 0 automatically once the data bits run out
    mod_dbl_add #(
        .DW (DW),
        .Q  (Q)
    ) u_step (
        .i_acc (r_acc),
        .i_b   (r_shift[DW-1]),
        .o_acc (w_acc_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        w_step = 1'b0;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_load = 1'b1;
                    w_next = RUN;
                end
            end
            RUN: begin
                w_step = 1'b1;
                if (r_cnt == LAST) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
        end else if (w_load) begin
            r_shift <= in_data;
            r_acc   <= '0;
            r_cnt   <= '0;
        end else if (w_step) begin
            r_shift <= {r_shift[DW-2:0], 1'b0};
            r_acc   <= w_acc_nxt;
            r_cnt   <= r_cnt + CW'(1);
        end
    end

    // acc is frozen outside RUN, so it doubles as the held output register
    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign out_data  = r_acc;

endmodule

// File: tb/tb_mont_dom_enc.sv
// Self-checking bench for mont_dom_enc: directed vector table, back-pressure and
// mid-run reset sequences, and a randomised stream checked through a scoreboard.
module tb_mont_dom_enc;

    localparam int unsigned LATENCY = 34;

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        busy;

    int          nChecks = 0;
    int          nPass   = 0;
    int          cyc     = 0;
    int          acceptEdge = 0;
    int          nIn     = 0;
    logic        prevOv  = 1'b0;
    logic        randMode = 1'b0;
    logic [15:0] curExp  = '0;
    logic [15:0] expQ[$];
    vec_t        vecs[9];

    mont_dom_enc dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Independent golden model: plain modular arithmetic on a wide integer
    function automatic logic [15:0] model(input logic [15:0] x);
        longint p;
        p = longint'(x) * 64'd262144;
        return 16'(p % 3329);
    endfunction

    task automatic checkOutput(input string name, input longint act, input longint exp);
        nChecks++;
        if (act == exp) nPass++;
        else $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic failNow(input string name);
        nChecks++;
        $display("[TB] FAIL %s: bound expired (t=%0t)", name, $time);
    endtask

    task automatic stepClk();
        @(posedge clk);
        #1;
    endtask

    // Monitor: sampled mid-cycle, so values equal what the next rising edge sees
    always @(negedge clk) begin
        if (!rst_n) begin
            prevOv = 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                expQ.push_back(curExp);
                acceptEdge = cyc + 1;
                nIn++;
            end
            if (out_valid && !prevOv) checkOutput("latency", cyc - acceptEdge, LATENCY);
            prevOv = out_valid;
            if (out_valid && out_ready) begin
                if (expQ.size() == 0) begin
                    nChecks++;
                    $display("[TB] FAIL spurious_output: got out_data=%0d, expected no output", out_data);
                end else begin
                    checkOutput("result", out_data, expQ.pop_front());
                end
            end
        end
    end

    // Random back-pressure on out_ready during the stream phase
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (randMode) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic applyStimulus(input logic [15:0] x, input logic [15:0] e);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_data  = x;
        curExp   = e;
        for (int n = 0; n < 300 && !done; n++) begin
            if (in_ready) done = 1'b1;
            stepClk();
        end
        in_valid = 1'b0;
        if (!done) failNow("accept_timeout");
    endtask

    task automatic drain();
        for (int n = 0; n < 400 && expQ.size() != 0; n++) stepClk();
        if (expQ.size() != 0) failNow("drain_timeout");
    endtask

    initial begin
        int ovSeen;
        int nInBefore;
        int gap;
        logic [15:0] x;

        vecs[0] = '{16'd1,     16'd2482};
        vecs[1] = '{16'd0,     16'd0};
        vecs[2] = '{16'd3329,  16'd0};
        vecs[3] = '{16'd6658,  16'd0};
        vecs[4] = '{16'd3328,  16'd847};
        vecs[5] = '{16'd65535, 16'd2930};
        vecs[6] = '{16'd2,     16'd1635};
        vecs[7] = '{16'd1664,  16'd2088};
        vecs[8] = '{16'd63251, 16'd0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_in_ready", in_ready, 1);
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_out_data", out_data, 0);
        rst_n = 1'b1;
        stepClk();

        // Directed table
        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].x, vecs[i].y);
            drain();
        end

        // Back-pressure: hold the result for 10 cycles while poking in_valid
        out_ready = 1'b0;
        applyStimulus(16'd3328, 16'd847);
        for (int n = 0; n < 100 && !out_valid; n++) stepClk();
        if (!out_valid) failNow("bp_wait_valid");
        nInBefore = nIn;
        for (int i = 0; i < 10; i++) begin
            in_valid = (i % 2 == 0);
            in_data  = 16'(i * 1000 + 5);
            curExp   = 16'hFFFF;
            stepClk();
            checkOutput("bp_out_data_held", out_data, 847);
            checkOutput("bp_in_ready_low", in_ready, 0);
            checkOutput("bp_out_valid_held", out_valid, 1);
        end
        in_valid = 1'b0;
        checkOutput("bp_no_extra_accept", nIn - nInBefore, 0);
        checkOutput("bp_queue_depth", expQ.size(), 1);
        out_ready = 1'b1;
        stepClk();
        checkOutput("bp_out_valid_fall", out_valid, 0);
        checkOutput("bp_in_ready_rise", in_ready, 1);
        checkOutput("bp_drained", expQ.size(), 0);

        // Reset in the middle of RUN
        applyStimulus(16'd77, model(16'd77));
        repeat (11) stepClk();
        checkOutput("run_busy", busy, 1);
        checkOutput("run_in_ready", in_ready, 0);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_in_ready", in_ready, 1);
        checkOutput("midrst_out_valid", out_valid, 0);
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_out_data", out_data, 0);
        expQ.delete();
        ovSeen = 0;
        for (int n = 0; n < 40; n++) begin
            stepClk();
            if (out_valid) ovSeen++;
            if (n == 2) rst_n = 1'b1;
        end
        checkOutput("midrst_no_out_valid", ovSeen, 0);
        applyStimulus(16'd1, 16'd2482);
        drain();

        // Random stream with input gaps and output back-pressure
        randMode = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            gap = $urandom_range(0, 2);
            repeat (gap) stepClk();
            x = 16'($urandom_range(0, 65535));
            applyStimulus(x, model(x));
        end
        drain();
        randMode  = 1'b0;
        out_ready = 1'b1;
        checkOutput("stream_no_loss", expQ.size(), 0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/mont_dom_enc.md
# mont_dom_enc

Iterative Montgomery-domain encoder for the NTT datapath: maps a coefficient x to x·R mod Q, where R = 2^18 (two 9-bit reduction words) and Q = 3329. It is the inverse of the Montgomery reduction stage, which maps C to C·R⁻¹ mod Q. Encoded coefficients enter the butterfly and multiply stages, and the reduction stage maps them back. The block uses a valid/ready stream and a serial MSB-first double-and-add core, so the datapath is one 12-bit modular step.

## Interface
- Q, default 16'd3329: odd modulus; constraint Q ≤ 2^(DW−1).
- DW, default 16: input/output data width.
- K, default 18: Montgomery exponent, R = 2^K.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept; high only in IDLE.
- in_data  input  DW  coefficient x, any value 0..2^DW−1 (need not be < Q).
- out_valid  output  1  out_data is valid; held until taken.
- out_ready  input  1  consumer accepts out_data.
- out_data  output  DW  y = (x·2^K) mod Q, always < Q, upper bits zero.
- busy  output  1  high in RUN or DONE.

## Operation
- Computes the (DW+K)-bit value x·2^K mod Q by Horner's rule, MSB first: acc ← (2·acc + b) mod Q.
  - For iterations 0..DW−1, b = in_data bits DW−1..0.
  - For the remaining K iterations, b = 0.
- Step arithmetic:
  - t = {acc,1'b0} + b, computed at DW+1 bits.
  - If t ≥ Q, acc ← t − Q; otherwise acc ← t.
  - acc < Q is invariant, so a single conditional subtract suffices.
  - No multiplier is used.
- FSM states IDLE, RUN, DONE.
  - IDLE: in_ready = 1. On in_valid & in_ready, load shift register ← in_data, acc ← 0, cnt ← 0, go to RUN.
  - RUN: one step per cycle, shift register shifts left with zero fill, cnt increments. When cnt = DW+K−1, the step executes and the FSM goes to DONE.
  - DONE: out_valid = 1, out_data = acc. On out_ready, go to IDLE.
- in_ready is low in RUN and DONE. in_valid outside IDLE is ignored and the data is not latched.
- out_data is stable while out_valid is high and out_ready is low.
- Reset: asynchronous, applies mid-RUN or mid-DONE. The state goes to IDLE, the in-flight result is discarded and no out_valid pulse is produced.

## Timing
- Reset values: in_ready = 1, out_valid = 0, out_data = 0, busy = 0, acc = 0, cnt = 0.
- Accept on edge E. Steps execute on edges E+1 .. E+DW+K, which is E+34 at the defaults.
- out_valid rises after edge E+DW+K, so latency is DW+K cycles from accept to first valid.
- Output handshake on edge F (out_ready high): out_valid falls and in_ready rises after F. The next accept is possible at F+1 at the earliest, with no same-cycle turnaround.
- Maximum throughput is one coefficient per DW+K+2 cycles (36 at the defaults).
- Boundary cases:
  - in_data = 0 gives 0.
  - in_data = Q or a multiple of Q gives 0.
  - in_data = 2^DW−1 exercises the full pre-reduction.
  - t = Q exactly must subtract, giving 0.
- cnt width is ceil(log2(DW+K)), 6 bits at the defaults. It does not wrap because the FSM leaves RUN at the terminal count.

## Structure
- Package mont_pkg:
  - Q, K, DW constants.
  - R_MOD_Q = 2482 and R2_MOD_Q = 1674, for the bench and the later multiply stage.
  - enc_state_t enum {IDLE, RUN, DONE}.
- One combinational sub-module, mod_dbl_add (acc, b → next acc), instanced once. It is reusable by the future serial mod-multiplier.
- The top level holds the FSM, counter, shift register, acc and output register.

## Test plan
- Reset then in_data = 1 → out_data = 2482, with out_valid exactly 34 cycles after the accept edge.
- in_data = 0 and in_data = 3329 → out_data = 0 in both cases.
- in_data = 3328 (−1 mod Q) → 847; in_data = 65535 → 2930.
- Back-pressure: hold out_ready = 0 for 10 cycles in DONE → out_data held stable, in_ready stays 0, and in_valid pulses in that window are not accepted.
- Assert rst_n low mid-RUN (cycle 12) → outputs return to reset values immediately, no out_valid, and the next transaction computes correctly.
- Random stream of 1000 inputs with random valid/ready gaps → every result matches the golden model (x·2482) mod 3329, in order, with no loss or duplication.
